mux_4to1_rr: RTL and testbench
==============================

# mux_4to1_rr

Four-input, round-robin arbitrated, registered 4-to-1 multiplexer: the merging counterpart of the 1-to-4 demultiplexer. It collects beats from four independent valid/ready source channels and forwards them one per cycle onto a single output channel. It tags each output beat with the index of the channel it came from, so a downstream `demux_1to4_d` driven by that tag restores the original split. The block sits between the four lane producers and the shared 16-bit datapath.

## Interface
- `width`, 16, data width of every input and output beat

- `clk` input 1: single clock, all state updates on rising edge
- `rst` input 1: reset, synchronous, active-high
- `i0`, `i1`, `i2`, `i3` input `width`: data of source channels 0..3
- `v_i` input 4: `v_i[k]` = channel k presents a valid beat on `ik`
- `r_i` output 4: `r_i[k]` = channel k's beat is accepted this cycle
- `o` output `width`: registered output data
- `sel` output 2: source channel index of the beat on `o`
- `v_o` output 1: `o` / `sel` hold a valid beat
- `r_o` input 1: downstream accepts the output beat this cycle

## Operation
- One output register stage (`o`, `sel`, `v_o`) and a 2-bit round-robin pointer `ptr` (the highest-priority channel).
- Two states:
  - EMPTY: `v_o`=0.
  - FULL: `v_o`=1.
- Load enable: `ld = !rst && (!v_o || r_o)`.
- Grant: when `ld`=1 and `v_i`≠0, grant `g` = first k with `v_i[k]`=1, searching `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4).
- `r_i` is one-hot with bit `g` set when `ld`=1 and `v_i`≠0; otherwise `r_i`=0. `r_i` is combinational from `v_i`, `v_o`, `r_o`, `ptr`, `rst`.
- On a granted cycle: `o`←`i[g]`, `sel`←`g`, `v_o`←1, `ptr`←`g+1` (mod 4, 3 wraps to 0).
- On `ld`=1 with `v_i`=0: `v_o`←0. `o`, `sel` and `ptr` hold.
- On `ld`=0 (FULL and `r_o`=0): everything holds, `r_i`=0. This is backpressure: the output beat stays stable until `r_o`=1.
- State transitions:
  - EMPTY→FULL when any `v_i`.
  - FULL→FULL on `r_o`=1 with any `v_i` (back-to-back), or on `r_o`=0.
  - FULL→EMPTY on `r_o`=1 with `v_i`=0.
- `ptr` advances only on a grant, never on idle or stall cycles.
- Data passes unmodified; no width conversion.

## Timing
- Reset values (cycle after `rst`=1 sampled): `o`=0, `sel`=0, `v_o`=0, `ptr`=0. `r_i`=0 while `rst`=1.
- Latency: a beat accepted at edge N appears on `o` with `v_o`=1 after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle when `r_o` is held at 1.
- Simultaneous `r_o`=1 and new grant in the same cycle: the old beat leaves and the new beat loads at the same edge, with no bubble.
- Fairness: with all four `v_i` held at 1, grants rotate 0,1,2,3,0,…; each channel waits at most 3 beats.
- Reset mid-operation: a beat held in the register is dropped (`v_o`→0); no `r_i` pulse occurs during the reset cycle, so no source beat is lost.
- Sources must hold `ik` and `v_i[k]` stable until `r_i[k]`=1. The block does not require `v_i` to stay high.

## Structure
- No shared package; `width` is the only parameter. `localparam` values for the 2-bit index width and channel count 4 stay local.
- One sub-module: `rr_arb_4`, a combinational rotate-priority arbiter.
  - Inputs: `req[3:0]`, `ptr[1:0]`.
  - Outputs: `gnt_idx[1:0]`, `gnt_any`.
- The top level holds the output register, `ptr` and the data mux built with `?:` on `gnt_idx`.

## Test plan
- Reset: assert `rst` 2 cycles with all `v_i`=1 → `v_o`=0, `o`=16'h0000, `sel`=0, `r_i`=4'b0000 throughout.
- Single source: `v_i`=4'b0100, `i2`=16'hC000, `r_o`=1 → `r_i`=4'b0100 for one cycle; next cycle `o`=16'hC000, `sel`=2, `v_o`=1; then `v_o`=0 once `v_i` drops.
- Round robin: `i0`..`i3` = 16'hA000, 16'hB000, 16'hC000, 16'hD000, all `v_i`=1, `r_o`=1 for 8 cycles → `sel` sequence 0,1,2,3,0,1,2,3 with matching `o`, and `v_o` continuously 1.
- Backpressure: FULL with `o`=16'hA000, hold `r_o`=0 for 3 cycles → `o`, `sel`, `v_o` stable and `r_i`=0. Raise `r_o` → the next beat loads on the same edge the old one leaves.
- Pointer wrap/skip: after a grant to channel 3, `v_i`=4'b1010 → grant goes to channel 1 (`ptr`=0 search hits 1 before 3).
- Mid-stream reset: `rst`=1 while FULL and `v_i`=4'b1111 → `v_o`=0 next cycle, no `r_i` pulse. After release, the first grant is channel 0.

Source files
------------

// File: rtl/rr_arb_4.sv
// Combinational rotate-priority arbiter for four requesters.
// Search starts at ptr and wraps; the first requester found wins.
module rr_arb_4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] gnt_idx,
    output logic       gnt_any
);

    localparam int NCH = 4;

    logic [1:0] idx;

    // Walk from the farthest offset down so the nearest hit wins.
    always_comb begin
        gnt_idx = ptr;
        gnt_any = 1'b0;
        idx     = ptr;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                gnt_idx = idx;
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_4to1_rr.sv
// Round-robin 4-to-1 merge with a single registered output stage.
// Each output beat is tagged with its source channel index on sel.
module mux_4to1_rr #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] i0,
    input  logic [width-1:0] i1,
    input  logic [width-1:0] i2,
    input  logic [width-1:0] i3,
    input  logic [3:0]       v_i,
    output logic [3:0]       r_i,
    output logic [width-1:0] o,
    output logic [1:0]       sel,
    output logic             v_o,
    input  logic             r_o
);

    localparam int IW = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    logic            ld;
    logic            grant;
    logic [width-1:0] din;

    rr_arb_4 u_arb (
        .req     (v_i),
        .ptr     (ptr),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign v_o   = (state == FULL);
    assign ld    = !rst && (!v_o || r_o);
    assign grant = ld && gnt_any;

    assign din = (gnt_idx == 2'd0) ? i0 :
                 (gnt_idx == 2'd1) ? i1 :
                 (gnt_idx == 2'd2) ? i2 : i3;

    always_comb begin
        state_nx = state;
        r_i      = 4'b0000;
        if (grant) begin
            r_i = 4'b0001 << gnt_idx;
        end
        if (ld) begin
            state_nx = gnt_any ? FULL : EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            o     <= '0;
            sel   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                o   <= din;
                sel <= gnt_idx;
                ptr <= gnt_idx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_mux_4to1_rr.sv
// Bench for mux_4to1_rr: directed vector table, then random
// traffic compared against a cycle-level reference model.
module tb_mux_4to1_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i0, i1, i2, i3;
    logic [3:0]  v_i;
    logic [3:0]  r_i;
    logic [15:0] o;
    logic [1:0]  sel;
    logic        v_o;
    logic        r_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_4to1_rr #(.width(16)) dut (
        .clk (clk),
        .rst (rst),
        .i0  (i0),
        .i1  (i1),
        .i2  (i2),
        .i3  (i3),
        .v_i (v_i),
        .r_i (r_i),
        .o   (o),
        .sel (sel),
        .v_o (v_o),
        .r_o (r_o)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic        ro;
        logic [3:0]  ri;
        logic        vo;
        logic [1:0]  sel;
        logic [15:0] o;
    } vec_t;

    vec_t tbl[25];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // reference model state
    int          m_vo, m_sel, m_ptr;
    logic [15:0] m_o;
    logic [15:0] d[4];

    initial begin
        // rst, v_i, r_o | r_i, v_o, sel, o (after the edge)
        tbl[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000};
        tbl[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000};
        tbl[2]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 16'hC000};
        tbl[3]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 16'hC000};
        tbl[4]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000};
        tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'hA000};
        tbl[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'hB000};
        tbl[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'hC000};
        tbl[8]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'hD000};
        tbl[9]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'hA000};
        tbl[10] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'hB000};
        tbl[11] = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'hC000};
        tbl[12] = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'hD000};
        tbl[13] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'hA000};
        tbl[14] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 16'hA000};
        tbl[15] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 16'hA000};
        tbl[16] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 16'hA000};
        tbl[17] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'hB000};
        tbl[18] = '{1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 16'hD000};
        tbl[19] = '{1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 16'hB000};
        tbl[20] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000};
        tbl[21] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'hA000};
        tbl[22] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 16'hA000};
        tbl[23] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 16'hC000};
        tbl[24] = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 16'hC000};

        rst = 1'b1;
        v_i = 4'b0000;
        r_o = 1'b0;
        i0  = 16'hA000;
        i1  = 16'hB000;
        i2  = 16'hC000;
        i3  = 16'hD000;
        @(posedge clk);
        #1;

        for (int n = 0; n < 25; n++) begin
            rst = tbl[n].rst;
            v_i = tbl[n].v;
            r_o = tbl[n].ro;
            #3;
            chk($sformatf("vec%0d r_i", n), 32'(r_i), 32'(tbl[n].ri));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d v_o", n), 32'(v_o), 32'(tbl[n].vo));
            chk($sformatf("vec%0d sel", n), 32'(sel), 32'(tbl[n].sel));
            chk($sformatf("vec%0d o", n), 32'(o), 32'(tbl[n].o));
        end

        // random traffic; first cycle forces reset to align the model
        m_vo  = 0;
        m_sel = 0;
        m_ptr = 0;
        m_o   = '0;
        for (int n = 0; n < 600; n++) begin
            int g;
            int c;
            logic [3:0] exp_ri;
            rst = (n == 0) || ($urandom_range(0, 59) == 0);
            v_i = 4'($urandom);
            r_o = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) d[k] = 16'($urandom);
            i0 = d[0];
            i1 = d[1];
            i2 = d[2];
            i3 = d[3];
            g = -1;
            if (!rst && (m_vo == 0 || r_o)) begin
                for (int k = 0; k < 4; k++) begin
                    c = (m_ptr + k) % 4;
                    if (g < 0 && v_i[c]) g = c;
                end
            end
            exp_ri = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            #3;
            chk("rand r_i", 32'(r_i), 32'(exp_ri));
            @(posedge clk);
            if (rst) begin
                m_vo  = 0;
                m_sel = 0;
                m_ptr = 0;
                m_o   = '0;
            end else if (m_vo == 0 || r_o) begin
                if (g >= 0) begin
                    m_o   = d[g];
                    m_sel = g;
                    m_vo  = 1;
                    m_ptr = (g + 1) % 4;
                end else begin
                    m_vo = 0;
                end
            end
            #1;
            chk("rand v_o", 32'(v_o), 32'(m_vo));
            if (m_vo != 0) begin
                chk("rand sel", 32'(sel), 32'(m_sel));
                chk("rand o", 32'(o), 32'(m_o));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
